// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: IF stage issuing sequential word reads and buffering in-order responses for the decoder.
// Credits cover in-flight reads plus buffered entries, so a non-stale response always finds a free slot.
module instr_fetch_unit #(
  parameter int              XLEN         = 32,
  parameter int              IF_LEN       = 32,
  parameter int              IF_INC       = 4,
  parameter logic [XLEN-1:0] IF_BASE_ADDR = 32'h1000_0000,
  parameter logic [XLEN-1:0] IF_MAX_ADDR  = 32'h1000_3FFF,
  parameter int              FIFO_DEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [IF_LEN-1:0] mem_rsp_data,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_addr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [IF_LEN-1:0] instr_data,
  output logic [XLEN-1:0]   instr_pc,
  output logic              instr_fault,
  output logic              flush_pulse
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [XLEN-1:0] LAST_ADDR = IF_MAX_ADDR - XLEN'(3);
  localparam logic [IF_LEN-1:0] NOP = IF_LEN'(32'h0000_0013);
  typedef enum logic [1:0] {RUN, FAULT_PEND, HALT} state_t;
  state_t r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_rsp_pc, w_push_pc;
  logic [CW-1:0] r_count, r_outstanding, r_discard;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [XLEN-1:0] r_fifo_pc [FIFO_DEPTH];
  logic [IF_LEN-1:0] r_fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_fifo_fault;
  logic [IF_LEN-1:0] w_push_data;
  logic r_flush, w_legal, w_issue, w_drop, w_rsp_push, w_fault_push, w_push, w_pop;
  // Live reads are always the newest issues, so the oldest one sits outstanding words behind pc.
  always_comb begin
    w_legal = (r_pc >= IF_BASE_ADDR) && (r_pc <= LAST_ADDR) && (r_pc[1:0] == 2'b00);
    mem_req_valid = rst_n && (r_state == RUN) && w_legal && (r_outstanding + r_count < DEPTH_C) &&
                    (r_discard == '0) && !redirect_valid;
    w_issue = mem_req_valid && mem_req_ready;
    w_drop = mem_rsp_valid && (r_discard != '0);
    w_rsp_push = mem_rsp_valid && (r_discard == '0) && !redirect_valid;
    w_fault_push = (r_state != HALT) && !w_legal && (r_outstanding == '0) && (r_count < DEPTH_C) && !redirect_valid;
    w_push = w_rsp_push || w_fault_push;
    w_pop = instr_valid && instr_ready && !redirect_valid;
    w_rsp_pc = r_pc - XLEN'(IF_INC) * XLEN'(r_outstanding);
    w_push_pc = w_fault_push ? r_pc : w_rsp_pc;
    w_push_data = w_fault_push ? NOP : mem_rsp_data;
    w_state_nxt = redirect_valid ? RUN :
                  w_fault_push ? HALT :
                  (r_state == RUN && !w_legal) ? FAULT_PEND : r_state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RUN;
    else r_state <= w_state_nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= IF_BASE_ADDR;
      r_count <= '0;
      r_outstanding <= '0;
      r_discard <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_flush <= 1'b0;
      r_fifo_fault <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_pc[i] <= '0;
        r_fifo_data[i] <= '0;
      end
    end else begin
      r_flush <= redirect_valid;
      if (redirect_valid) begin
        r_pc <= redirect_addr;
        r_count <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_outstanding <= '0;
        r_discard <= r_discard + r_outstanding - CW'(mem_rsp_valid);
      end else begin
        if (w_issue) r_pc <= r_pc + XLEN'(IF_INC);
        r_outstanding <= r_outstanding + CW'(w_issue) - CW'(w_rsp_push);
        r_discard <= r_discard - CW'(w_drop);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
        if (w_push) begin
          r_fifo_pc[r_wr_ptr] <= w_push_pc;
          r_fifo_data[r_wr_ptr] <= w_push_data;
          r_fifo_fault[r_wr_ptr] <= w_fault_push;
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n && mem_rsp_valid && r_discard == '0) assert (r_count < DEPTH_C && r_outstanding != '0);
  end
  assign mem_req_addr = r_pc;
  assign instr_valid = (r_count != '0);
  assign instr_pc = r_fifo_pc[r_rd_ptr];
  assign instr_data = r_fifo_data[r_rd_ptr];
  assign instr_fault = r_fifo_fault[r_rd_ptr];
  assign flush_pulse = r_flush;
endmodule
